shift_issue: RTL
================

Name: shift_issue

Overview:
- Issue/translate stage directly upstream of the 16-bit barrel shifter in the execute path.
- Accepts shift commands (operand, opcode, unsigned amount, destination tag) over a valid/ready handshake.
- Converts each command into the shifter's control encoding: `ain`, signed 5-bit `bin` (positive = right, negative = left), `rotate`, `sra`.
- Buffers up to DEPTH commands and presents them downstream through a second valid/ready handshake.

Parameters:
- WIDTH, 16, operand width; must match the barrel shifter.
- DEPTH, 2, command FIFO entries; power of two, ≥2.
- TAGW, 4, destination tag width, carried unchanged.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  command present.
- in_ready  out  1  stage can accept; equals !full.
- in_op  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL, 101–111 illegal.
- in_amt  in  5  unsigned shift amount 0..31.
- in_a  in  WIDTH  operand.
- in_tag  in  TAGW  destination tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  shifter/writeback consumes head.
- out_ain  out  WIDTH  to barrel shifter `ain`.
- out_bin  out  5  to barrel shifter `bin` (two's complement).
- out_rotate  out  1  to barrel shifter `rotate`.
- out_sra  out  1  to barrel shifter `sra`.
- out_tag  out  TAGW  tag of head entry.
- out_err  out  1  head entry had an illegal opcode.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - FIFO emptied, pointers and count = 0.
  - out_valid = 0, in_ready = 1.
  - out_ain, out_bin, out_tag = 0; out_rotate, out_sra, out_err = 0.
  - In-flight entries are discarded.
- Accept when in_valid & in_ready at a rising edge; pop when out_valid & out_ready.
- Translation is combinational on input; the translated entry is written into the FIFO.
- Latency: accepted into an empty FIFO → out_valid = 1 the next cycle. No same-cycle pass-through.
- Outputs are driven from the FIFO head register; they hold stable while out_valid & !out_ready.
- Translation rules (a = in_a, k = in_amt):
  - SLL, k ≤ 16: ain = a, bin = −k (k = 0 → bin = 0; k = 16 → bin = 5'b10000), rotate = 0, sra = 0.
  - SLL, k > 16: ain = 0, bin = 0.
  - SRL, k ≤ 15: ain = a, bin = k, rotate = 0, sra = 0.
  - SRL, k ≥ 16: ain = 0, bin = 0.
  - SRA, k ≤ 15: ain = a, bin = k, sra = 1.
  - SRA, k ≥ 16: ain = a, bin = 15, sra = 1 (full sign fill).
  - ROR: r = k mod 16; ain = a, bin = r, rotate = 1.
  - ROL: r = k mod 16; ain = a, bin = −r (r = 0 → bin = 0), rotate = 1.
  - Illegal op: ain = a, bin = 0, rotate = 0, sra = 0, err = 1. The command is still accepted and queued (no stall).
- Full: in_ready = 0. Simultaneous pop while full does not admit a new entry in that cycle; in_ready rises the cycle after the pop.
- Empty: out_valid = 0 and out_* fields hold their last values (don't-care for verification, except after reset where they are 0).
- Simultaneous push and pop when 0 < count < DEPTH: count unchanged, order preserved.
- Pointers wrap modulo DEPTH. Strict FIFO order; tags never reordered.
- in_* sampled only on accept; changes while in_ready = 0 have no effect.
- count increments on push-only, decrements on pop-only, never exceeds DEPTH, never underflows.

Test Plan:
1. Reset, then push SRL a = 16'h0FD6, amt = 6, tag = 3; out_ready = 1 → next cycle: out_valid = 1, out_ain = 16'h0FD6, out_bin = 5'b00110, rotate = 0, sra = 0, tag = 3. Popped the following cycle; count returns to 0.
2. Boundary amounts:
   - SLL amt 16 → bin = 5'b10000, ain = a.
   - SLL amt 17 → ain = 0, bin = 0.
   - SRL amt 16 → ain = 0.
   - SRA a = 16'hCFD6 amt 20 → bin = 15, sra = 1.
3. Rotates:
   - ROL amt 15 → bin = 5'b10001, rotate = 1.
   - ROR amt 22 → bin = 6.
   - ROL amt 16 → bin = 0, rotate = 1.
4. Backpressure: out_ready = 0, push 3 commands → third held (in_ready = 0 after 2 accepts, count = 2). Outputs stable on first entry. Release out_ready → entries emerge in tag order; in_ready reasserts one cycle after first pop.
5. Streaming: in_valid and out_ready held high with count = 1 for 10 cycles → one accept and one pop per cycle, count stays 1, tags in order.
6. Illegal op 3'b110 → accepted, out_err = 1, bin = 0. Assert reset while count = 2 → out_valid = 0, count = 0, in_ready = 1 immediately (asynchronous).

Source files
------------

// File: rtl/shift_issue.sv
// Issue stage in front of the 16-bit barrel shifter: translates shift commands into
// shifter controls (ain, signed bin, rotate, sra) and queues them in a small FIFO.
module shift_issue #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAGW  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_op,
  input  logic [4:0]                 in_amt,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [TAGW-1:0]            in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_ain,
  output logic [4:0]                 out_bin,
  output logic                       out_rotate,
  output logic                       out_sra,
  output logic [TAGW-1:0]            out_tag,
  output logic                       out_err,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;

  logic [WIDTH-1:0] ain_q [DEPTH];
  logic [4:0]       bin_q [DEPTH];
  logic             rot_q [DEPTH];
  logic             sra_q [DEPTH];
  logic             err_q [DEPTH];
  logic [TAGW-1:0]  tag_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  logic [WIDTH-1:0] t_ain;
  logic [4:0]       t_bin;
  logic             t_rot, t_sra, t_err;
  logic             push, pop;

  // bin is two's complement: negative shifts left, positive shifts right.
  always_comb begin
    t_ain = in_a;
    t_bin = 5'd0;
    t_rot = 1'b0;
    t_sra = 1'b0;
    t_err = 1'b0;
    case (in_op)
      OP_SLL: begin
        if (in_amt > 5'd16) t_ain = '0;
        else                t_bin = 5'd0 - in_amt;
      end
      OP_SRL: begin
        if (in_amt > 5'd15) t_ain = '0;
        else                t_bin = in_amt;
      end
      OP_SRA: begin
        t_sra = 1'b1;
        t_bin = (in_amt > 5'd15) ? 5'd15 : in_amt;
      end
      OP_ROR: begin
        t_rot = 1'b1;
        t_bin = {1'b0, in_amt[3:0]};
      end
      OP_ROL: begin
        t_rot = 1'b1;
        t_bin = 5'd0 - {1'b0, in_amt[3:0]};
      end
      default: t_err = 1'b1;
    endcase
  end

  assign in_ready  = (count_q != FullCount);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ain_q[i] <= '0;
        bin_q[i] <= '0;
        rot_q[i] <= 1'b0;
        sra_q[i] <= 1'b0;
        err_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (push) begin
        ain_q[wr_ptr_q] <= t_ain;
        bin_q[wr_ptr_q] <= t_bin;
        rot_q[wr_ptr_q] <= t_rot;
        sra_q[wr_ptr_q] <= t_sra;
        err_q[wr_ptr_q] <= t_err;
        tag_q[wr_ptr_q] <= in_tag;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign out_ain    = ain_q[rd_ptr_q];
  assign out_bin    = bin_q[rd_ptr_q];
  assign out_rotate = rot_q[rd_ptr_q];
  assign out_sra    = sra_q[rd_ptr_q];
  assign out_err    = err_q[rd_ptr_q];
  assign out_tag    = tag_q[rd_ptr_q];
  assign count      = count_q;

endmodule
